// File: rtl/mul16u_prod_accum.sv
// Registered MAC tail behind the 16x16 approximate multiplier: accumulates a
// packet of products (plus optional bias) and holds the packet result until taken.
module mul16u_prod_accum #(
  parameter int unsigned         PROD_W = 32,
  parameter int unsigned         ACC_W  = 40,
  parameter int unsigned         CNT_W  = 8,
  parameter logic [PROD_W-1:0]   BIAS   = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid_i,
  output logic              prod_ready_o,
  input  logic [PROD_W-1:0] prod_data_i,
  input  logic              prod_last_i,
  input  logic              clr_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [ACC_W-1:0]  res_data_o,
  output logic [CNT_W-1:0]  res_count_o,
  output logic              res_sat_o
);

  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic {ACC, HOLD} state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sat_q;
  logic               resValid_q;
  logic [ACC_W-1:0]   resData_q;
  logic [CNT_W-1:0]   resCount_q;
  logic               resSat_q;

  logic [ACC_W-1:0]   accBase;
  logic [CNT_W-1:0]   cntBase;
  logic [SUM_W-1:0]   sum;
  logic               ovf;
  logic               accept;
  logic [ACC_W-1:0]   acc_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               sat_d;

  // The extra sum bit catches overflow; ACC_W >= PROD_W+1 keeps base+prod+bias inside it.
  always_comb begin
    accBase = clr_i ? '0 : acc_q;
    cntBase = clr_i ? '0 : cnt_q;
    sum     = {1'b0, accBase} + SUM_W'(prod_data_i) + SUM_W'(BIAS);
    ovf     = sum[ACC_W];
    acc_d   = ovf ? '1 : sum[ACC_W-1:0];
    cnt_d   = (&cntBase) ? cntBase : cntBase + 1'b1;
    sat_d   = (clr_i ? 1'b0 : sat_q) | ovf;
    accept  = prod_valid_i && (state_q == ACC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ACC;
      acc_q      <= '0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      resValid_q <= 1'b0;
      resData_q  <= '0;
      resCount_q <= '0;
      resSat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (accept && prod_last_i) begin
            resData_q  <= acc_d;
            resCount_q <= cnt_d;
            resSat_q   <= sat_d;
            resValid_q <= 1'b1;
            state_q    <= HOLD;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
          end else if (accept) begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
          end else if (clr_i) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
          end
        end
        HOLD: begin
          if (res_ready_i) begin
            resValid_q <= 1'b0;
            state_q    <= ACC;
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign prod_ready_o = (state_q == ACC);
  assign res_valid_o  = resValid_q;
  assign res_data_o   = resData_q;
  assign res_count_o  = resCount_q;
  assign res_sat_o    = resSat_q;

endmodule

// File: tb/tb_mul16u_prod_accum.sv
// Bench for mul16u_prod_accum: three instances (default, BIAS=0x10000, ACC_W=33)
// share one stimulus stream; expected packet results go through a scoreboard queue.
module tb_mul16u_prod_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prod_valid = 1'b0;
  logic [31:0] prod_data = '0;
  logic        prod_last = 1'b0;
  logic        clr = 1'b0;
  logic        res_ready = 1'b0;

  logic        readyM, readyB, readyN;
  logic        validM, validB, validN;
  logic [39:0] dataM, dataB;
  logic [32:0] dataN;
  logic [7:0]  countM, countB, countN;
  logic        satM, satB, satN;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    logic [39:0] mainData;
    logic [32:0] narData;
    logic [39:0] biasData;
    logic [7:0]  count;
    logic        mainSat;
    logic        narSat;
  } exp_t;

  exp_t sbQ[$];
  exp_t exp;

  always #5 clk = ~clk;

  mul16u_prod_accum dutMain (
    .clk(clk), .rst(rst), .prod_valid_i(prod_valid), .prod_ready_o(readyM),
    .prod_data_i(prod_data), .prod_last_i(prod_last), .clr_i(clr),
    .res_valid_o(validM), .res_ready_i(res_ready), .res_data_o(dataM),
    .res_count_o(countM), .res_sat_o(satM)
  );

  mul16u_prod_accum #(.BIAS(32'h0001_0000)) dutBias (
    .clk(clk), .rst(rst), .prod_valid_i(prod_valid), .prod_ready_o(readyB),
    .prod_data_i(prod_data), .prod_last_i(prod_last), .clr_i(clr),
    .res_valid_o(validB), .res_ready_i(res_ready), .res_data_o(dataB),
    .res_count_o(countB), .res_sat_o(satB)
  );

  mul16u_prod_accum #(.ACC_W(33)) dutNarrow (
    .clk(clk), .rst(rst), .prod_valid_i(prod_valid), .prod_ready_o(readyN),
    .prod_data_i(prod_data), .prod_last_i(prod_last), .clr_i(clr),
    .res_valid_o(validN), .res_ready_i(res_ready), .res_data_o(dataN),
    .res_count_o(countN), .res_sat_o(satN)
  );

  // Drive one beat and hold it until the edge that accepts it; returns at edge+1.
  task automatic applyStimulus(input logic [31:0] d, input logic l, input logic c);
    int waitCycles;
    prod_valid = 1'b1;
    prod_data  = d;
    prod_last  = l;
    clr        = c;
    waitCycles = 0;
    while (!readyM && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    if (!readyM) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL beat_accept_timeout: prod_ready=%b required 1", readyM);
    end
    @(posedge clk); #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
    clr        = 1'b0;
  endtask

  task automatic waitValid();
    for (int i = 0; i < 20 && !validM; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    assertCount++;
    if ({validM, dataM, countM, satM, readyM} !== {1'b0, 40'h0, 8'h0, 1'b0, 1'b1}) begin
      failCount++;
      $display("[TB] FAIL reset_state: valid=%b data=%h count=%0d sat=%b ready=%b required 0/0/0/0/1",
               validM, dataM, countM, satM, readyM);
    end
  endtask

  task automatic test_accumulate();
    sbQ.push_back('{40'h6_0000, 33'h6_0000, 40'h9_0000, 8'd3, 1'b0, 1'b0});
    applyStimulus(32'h0001_0000, 1'b0, 1'b0);
    applyStimulus(32'h0002_0000, 1'b0, 1'b0);
    applyStimulus(32'h0003_0000, 1'b1, 1'b0);
    assertCount++;
    if (validM !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL accumulate_latency: res_valid=%b required 1", validM);
    end
    exp = sbQ.pop_front();
    assertCount++;
    if ({dataM, countM, satM} !== {exp.mainData, exp.count, exp.mainSat}) begin
      failCount++;
      $display("[TB] FAIL accumulate_main: got %h/%0d/%b required %h/%0d/%b", dataM, countM, satM, exp.mainData, exp.count, exp.mainSat);
    end
    assertCount++;
    if ({dataB, countB, satB} !== {exp.biasData, exp.count, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL accumulate_bias: got %h/%0d/%b required %h/%0d/0", dataB, countB, satB, exp.biasData, exp.count);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    assertCount++;
    if (validM !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL accumulate_handshake: res_valid=%b required 0", validM);
    end
  endtask

  task automatic test_bias_single();
    sbQ.push_back('{40'h0, 33'h0, 40'h1_0000, 8'd1, 1'b0, 1'b0});
    applyStimulus(32'h0, 1'b1, 1'b0);
    waitValid();
    exp = sbQ.pop_front();
    assertCount++;
    if ({validB, dataB, countB, satB} !== {1'b1, exp.biasData, exp.count, 1'b0}) begin
      failCount++;
      $display("[TB] FAIL bias_single: got v=%b %h/%0d/%b required v=1 %h/%0d/0", validB, dataB, countB, satB, exp.biasData, exp.count);
    end
    assertCount++;
    if ({dataM, countM} !== {exp.mainData, exp.count}) begin
      failCount++;
      $display("[TB] FAIL bias_single_main: got %h/%0d required %h/%0d", dataM, countM, exp.mainData, exp.count);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_saturation();
    sbQ.push_back('{40'h2_FFFF_FFFD, 33'h1_FFFF_FFFF, 40'h3_0002_FFFD, 8'd3, 1'b0, 1'b1});
    for (int i = 0; i < 3; i++) applyStimulus(32'hFFFF_FFFF, (i == 2), 1'b0);
    waitValid();
    exp = sbQ.pop_front();
    assertCount++;
    if ({validN, dataN, countN, satN} !== {1'b1, exp.narData, exp.count, exp.narSat}) begin
      failCount++;
      $display("[TB] FAIL saturation_narrow: got v=%b %h/%0d/%b required v=1 %h/%0d/%b", validN, dataN, countN, satN, exp.narData, exp.count, exp.narSat);
    end
    assertCount++;
    if ({dataM, countM, satM} !== {exp.mainData, exp.count, exp.mainSat}) begin
      failCount++;
      $display("[TB] FAIL saturation_main: got %h/%0d/%b required %h/%0d/%b", dataM, countM, satM, exp.mainData, exp.count, exp.mainSat);
    end
    assertCount++;
    if (dataB !== exp.biasData) begin
      failCount++;
      $display("[TB] FAIL saturation_bias: got %h required %h", dataB, exp.biasData);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int badCycles;
    applyStimulus(32'h1, 1'b1, 1'b0);
    prod_valid = 1'b1;
    prod_data  = 32'h7;
    prod_last  = 1'b0;
    badCycles  = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if ({readyM, validM, dataM, countM} !== {1'b0, 1'b1, 40'h1, 8'd1}) badCycles++;
    end
    assertCount++;
    if (badCycles != 0) begin
      failCount++;
      $display("[TB] FAIL backpressure_stable: %0d bad cycles, last ready=%b valid=%b data=%h count=%0d required 0/1/1/1",
               badCycles, readyM, validM, dataM, countM);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    assertCount++;
    if ({validM, readyM, dataM} !== {1'b0, 1'b1, 40'h1}) begin
      failCount++;
      $display("[TB] FAIL backpressure_release: valid=%b ready=%b data=%h required 0/1/1", validM, readyM, dataM);
    end
    @(posedge clk); #1;
    prod_valid = 1'b0;
    sbQ.push_back('{40'h7, 33'h7, 40'h2_0007, 8'd2, 1'b0, 1'b0});
    applyStimulus(32'h0, 1'b1, 1'b0);
    waitValid();
    exp = sbQ.pop_front();
    assertCount++;
    if ({validM, dataM, countM, dataB} !== {1'b1, exp.mainData, exp.count, exp.biasData}) begin
      failCount++;
      $display("[TB] FAIL backpressure_next: got v=%b %h/%0d bias %h required v=1 %h/%0d bias %h", validM, dataM, countM, dataB, exp.mainData, exp.count, exp.biasData);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_clear();
    sbQ.push_back('{40'h20, 33'h20, 40'h1_0020, 8'd1, 1'b0, 1'b0});
    applyStimulus(32'h500, 1'b0, 1'b0);
    applyStimulus(32'h20, 1'b1, 1'b1);
    waitValid();
    exp = sbQ.pop_front();
    assertCount++;
    if ({validM, dataM, countM, dataB} !== {1'b1, exp.mainData, exp.count, exp.biasData}) begin
      failCount++;
      $display("[TB] FAIL clear_with_beat: got v=%b %h/%0d bias %h required v=1 %h/%0d bias %h", validM, dataM, countM, dataB, exp.mainData, exp.count, exp.biasData);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    applyStimulus(32'h11, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    assertCount++;
    if (validM !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_in_hold: res_valid=%b required 0", validM);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    assertCount++;
    if ({readyM, dataM, countM} !== {1'b1, 40'h0, 8'h0}) begin
      failCount++;
      $display("[TB] FAIL reset_release: ready=%b data=%h count=%0d required 1/0/0", readyM, dataM, countM);
    end
    applyStimulus(32'h300, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    sbQ.push_back('{40'h4, 33'h4, 40'h1_0004, 8'd1, 1'b0, 1'b0});
    applyStimulus(32'h4, 1'b1, 1'b0);
    waitValid();
    exp = sbQ.pop_front();
    assertCount++;
    if ({validM, dataM, countM, dataB} !== {1'b1, exp.mainData, exp.count, exp.biasData}) begin
      failCount++;
      $display("[TB] FAIL reset_midpacket: got v=%b %h/%0d bias %h required v=1 %h/%0d bias %h", validM, dataM, countM, dataB, exp.mainData, exp.count, exp.biasData);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_accumulate();
    test_bias_single();
    test_saturation();
    test_backpressure();
    test_clear();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
